my_univ_reg: RTL and testbench



---
 rtl/my_univ_reg.sv | 108 ++++++++++
 tb/tb_my_univ_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/my_univ_reg.sv
`default_nettype none
// ============================================================================
// Module   : my_univ_reg
// Brief    : WIDTH-bit universal register (load/shift/rotate/inc/dec) with
//            runtime reset value, clock enable and carry/borrow flag.
// Revision : 1.0 - initial release
// ============================================================================
module my_univ_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] in,
    input  logic             sin,
    input  logic [WIDTH-1:0] rval,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero
);

    localparam logic [2:0] c_MODE_HOLD = 3'b000;
    localparam logic [2:0] c_MODE_LOAD = 3'b001;
    localparam logic [2:0] c_MODE_SHL  = 3'b010;
    localparam logic [2:0] c_MODE_SHR  = 3'b011;
    localparam logic [2:0] c_MODE_ROL  = 3'b100;
    localparam logic [2:0] c_MODE_ROR  = 3'b101;
    localparam logic [2:0] c_MODE_INC  = 3'b110;
    localparam logic [2:0] c_MODE_DEC  = 3'b111;
    localparam logic [WIDTH:0] c_ONE   = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;

    // Each candidate is WIDTH+1 bits wide so the bit leaving the register
    // (or the arithmetic carry/borrow) sits in a fixed position; this also
    // keeps the WIDTH=1 case free of zero-width slices.
    logic [WIDTH:0] w_shl, w_shr, w_rol, w_ror, w_sum, w_diff;

    assign w_shl  = {out_q, sin};
    assign w_shr  = {sin, out_q};
    assign w_rol  = {out_q, out_q[WIDTH-1]};
    assign w_ror  = {out_q[0], out_q};
    assign w_sum  = {1'b0, out_q} + c_ONE;
    assign w_diff = {1'b0, out_q} - c_ONE;

    always_comb begin
        out_d   = out_q;
        carry_d = carry_q;
        if (enable) begin
            case (mode)
                c_MODE_HOLD: begin
                    out_d   = out_q;
                    carry_d = carry_q;
                end
                c_MODE_LOAD: begin
                    out_d   = in;
                    carry_d = 1'b0;
                end
                c_MODE_SHL: begin
                    out_d   = w_shl[WIDTH-1:0];
                    carry_d = w_shl[WIDTH];
                end
                c_MODE_SHR: begin
                    out_d   = w_shr[WIDTH:1];
                    carry_d = w_shr[0];
                end
                c_MODE_ROL: begin
                    out_d   = w_rol[WIDTH-1:0];
                    carry_d = w_rol[WIDTH];
                end
                c_MODE_ROR: begin
                    out_d   = w_ror[WIDTH:1];
                    carry_d = w_ror[0];
                end
                c_MODE_INC: begin
                    out_d   = w_sum[WIDTH-1:0];
                    carry_d = w_sum[WIDTH];
                end
                c_MODE_DEC: begin
                    out_d   = w_diff[WIDTH-1:0];
                    carry_d = w_diff[WIDTH];
                end
                default: begin
                    out_d   = out_q;
                    carry_d = carry_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= rval;
            carry_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign zero  = (out_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_my_univ_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_my_univ_reg
// Brief    : Bench for my_univ_reg at WIDTH 8, 1 and 32 with a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_my_univ_reg;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [2:0]  mode;
    logic [63:0] in_v;
    logic        sin;
    logic [63:0] rval_v;

    logic [7:0]  o8;
    logic        c8, z8;
    logic [0:0]  o1;
    logic        c1, z1;
    logic [31:0] o32;
    logic        c32, z32;

    int n_vec;
    int n_err;

    typedef struct {
        int          k;
        logic [63:0] o;
        logic        c;
    } exp_t;

    exp_t        q[$];
    logic [63:0] mo[3];
    logic        mc[3];

    my_univ_reg #(.WIDTH(8)) u_d8 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .in(in_v[7:0]), .sin(sin), .rval(rval_v[7:0]),
        .out(o8), .carry(c8), .zero(z8)
    );

    my_univ_reg #(.WIDTH(1)) u_d1 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .in(in_v[0:0]), .sin(sin), .rval(rval_v[0:0]),
        .out(o1), .carry(c1), .zero(z1)
    );

    my_univ_reg #(.WIDTH(32)) u_d32 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .in(in_v[31:0]), .sin(sin), .rval(rval_v[31:0]),
        .out(o32), .carry(c32), .zero(z32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 1 : 32);
    endfunction

    // Reference behaviour for one edge; returns {carry, out}.
    function automatic logic [64:0] mdl(input int w, input logic rst, input logic en,
                                        input logic [2:0] md, input logic [63:0] cur,
                                        input logic cc, input logic [63:0] din,
                                        input logic s, input logic [63:0] rv);
        logic [63:0] m, o, cu;
        logic        c;
        m  = (64'd1 << w) - 64'd1;
        cu = cur & m;
        o  = cu;
        c  = cc;
        if (rst) begin
            o = rv & m;
            c = 1'b0;
        end else if (en) begin
            case (md)
                3'd1: begin o = din & m;                                c = 1'b0;      end
                3'd2: begin o = (cu << 1) | 64'(s);                     c = cu[w-1];   end
                3'd3: begin o = (cu >> 1) | (64'(s) << (w - 1));        c = cu[0];     end
                3'd4: begin o = (cu << 1) | 64'(cu[w-1]);               c = cu[w-1];   end
                3'd5: begin o = (cu >> 1) | (64'(cu[0]) << (w - 1));    c = cu[0];     end
                3'd6: begin o = cu + 64'd1;                             c = (cu == m); end
                3'd7: begin o = cu - 64'd1;                             c = (cu == 0); end
                default: begin end
            endcase
        end
        return {c, o & m};
    endfunction

    task automatic drain();
        exp_t        e;
        logic [63:0] obs_o;
        logic        obs_c, obs_z;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.k)
                0:       begin obs_o = {56'd0, o8};  obs_c = c8;  obs_z = z8;  end
                1:       begin obs_o = {63'd0, o1};  obs_c = c1;  obs_z = z1;  end
                default: begin obs_o = {32'd0, o32}; obs_c = c32; obs_z = z32; end
            endcase
            n_vec++;
            assert (obs_o === e.o) else begin
                n_err++;
                $error("FAIL sb_out w%0d: observed %h expected %h", width_of(e.k), obs_o, e.o);
            end
            n_vec++;
            assert (obs_c === e.c) else begin
                n_err++;
                $error("FAIL sb_carry w%0d: observed %b expected %b", width_of(e.k), obs_c, e.c);
            end
            n_vec++;
            assert (obs_z === (e.o == 64'd0)) else begin
                n_err++;
                $error("FAIL sb_zero w%0d: observed %b expected %b", width_of(e.k), obs_z, (e.o == 64'd0));
            end
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [2:0] md,
                        input logic [63:0] din, input logic s, input logic [63:0] rv);
        logic [64:0] res;
        exp_t        e;
        @(negedge clk);
        reset  = r;
        enable = en;
        mode   = md;
        in_v   = din;
        sin    = s;
        rval_v = rv;
        for (int k = 0; k < 3; k++) begin
            res   = mdl(width_of(k), r, en, md, mo[k], mc[k], din, s, rv);
            mo[k] = res[63:0];
            mc[k] = res[64];
            e.k = k;
            e.o = res[63:0];
            e.c = res[64];
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic chk8(input string tag, input logic [7:0] eo, input logic ec, input logic ez);
        n_vec++;
        assert (o8 === eo && c8 === ec && z8 === ez) else begin
            n_err++;
            $error("FAIL %s: observed out=%h carry=%b zero=%b expected out=%h carry=%b zero=%b",
                   tag, o8, c8, z8, eo, ec, ez);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        reset  = 1'b0;
        enable = 1'b0;
        mode   = 3'd0;
        in_v   = 64'd0;
        sin    = 1'b0;
        rval_v = 64'd0;

        // Reset, load, hold with mode wiggling under enable=0
        step(1'b1, 1'b0, 3'd0, 64'h0, 1'b0, 64'hDEAD_BEEF_0000_00A5);
        chk8("reset_a5", 8'hA5, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd1, 64'h1234_5678_9ABC_DE3C, 1'b0, 64'h0);
        chk8("load_3c", 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'(i + 5), 64'hFF, 1'b1, 64'h0);
            chk8("hold_3c", 8'h3C, 1'b0, 1'b0);
        end

        // Shift left then right from 0x81
        step(1'b0, 1'b1, 3'd1, 64'h81, 1'b0, 64'h0);
        step(1'b0, 1'b1, 3'd2, 64'h0, 1'b1, 64'h0);
        chk8("shl_03", 8'h03, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd3, 64'h0, 1'b0, 64'h0);
        chk8("shr_01", 8'h01, 1'b1, 1'b0);

        // Rotate left eight times from 0x80
        step(1'b0, 1'b1, 3'd1, 64'h80, 1'b0, 64'h0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 1'b1, 3'd4, 64'h0, 1'b0, 64'h0);
            chk8("rol", 8'(8'd1 << (k - 1)), (k == 1), 1'b0);
        end

        // Increment/decrement wrap around zero
        step(1'b0, 1'b1, 3'd1, 64'hFE, 1'b0, 64'h0);
        step(1'b0, 1'b1, 3'd6, 64'h0, 1'b0, 64'h0);
        chk8("inc_ff", 8'hFF, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd6, 64'h0, 1'b0, 64'h0);
        chk8("inc_wrap", 8'h00, 1'b1, 1'b1);
        step(1'b0, 1'b1, 3'd7, 64'h0, 1'b0, 64'h0);
        chk8("dec_borrow", 8'hFF, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd7, 64'h0, 1'b0, 64'h0);
        chk8("dec_fe", 8'hFE, 1'b0, 1'b0);

        // Reset overrides an enabled increment, counting resumes from rval
        step(1'b0, 1'b1, 3'd1, 64'h10, 1'b0, 64'h0);
        step(1'b1, 1'b1, 3'd6, 64'h0, 1'b0, 64'h77);
        chk8("rst_prio", 8'h77, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd6, 64'h0, 1'b0, 64'h0);
        chk8("resume_78", 8'h78, 1'b0, 1'b0);

        // Random sweep across all three widths
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(99) < 5), 1'($urandom_range(1)), 3'($urandom_range(7)),
                 {$urandom, $urandom}, 1'($urandom_range(1)), {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
